// File: rtl/stream_header_extractor_pkg.sv
// Shared types and geometry helpers for the stream header extractor.
package stream_pack;

  localparam int unsigned MAC_HEADER_BYTES = 12;

  typedef enum logic [2:0] {IDLE, HDR, BYP, PAY, FLUSH} state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned header_words(input int unsigned header_bytes,
                                               input int unsigned data_width);
    return (header_bytes + bytes_per_word(data_width) - 1) / bytes_per_word(data_width);
  endfunction

  function automatic int unsigned header_offset(input int unsigned header_bytes,
                                                input int unsigned data_width);
    return header_bytes % bytes_per_word(data_width);
  endfunction

endpackage

// File: rtl/stream_header_extractor_realigner.sv
// Holds the trailing W-OFFSET bytes of the previous word and splices them in front
// of the leading OFFSET bytes of the current word; bytes past the valid count are zeroed.
module st_byte_realigner
  import stream_pack::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OFFSET     = 2,
  parameter int unsigned EMPTY_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [EMPTY_W:0]      in_vbytes,
  input  logic                  load,
  output logic [DATA_WIDTH-1:0] join_data,
  output logic [EMPTY_W-1:0]    join_empty,
  output logic [DATA_WIDTH-1:0] flush_data,
  output logic [EMPTY_W-1:0]    flush_empty
);

  localparam int unsigned W = bytes_per_word(DATA_WIDTH);
  localparam int unsigned R = W - OFFSET;

  logic [R*8-1:0]     res_q, res_d;
  logic [EMPTY_W-1:0] fe_q, fe_d;

  always_comb begin
    res_d = res_q;
    fe_d  = fe_q;
    if (load) begin
      for (int unsigned b = 0; b < R; b++) begin
        res_d[(R-1-b)*8 +: 8] = (OFFSET + b < 32'(in_vbytes)) ? in_data[(R-1-b)*8 +: 8] : 8'h00;
      end
      // Empty count for a possible flush word carrying V-OFFSET residue bytes.
      fe_d = (32'(in_vbytes) > OFFSET) ? EMPTY_W'(W + OFFSET - 32'(in_vbytes)) : '0;
    end
  end

  always_comb begin
    join_data = '0;
    join_data[DATA_WIDTH-1 -: R*8] = res_q;
    for (int unsigned i = 0; i < OFFSET; i++) begin
      if (i < 32'(in_vbytes)) join_data[(OFFSET-1-i)*8 +: 8] = in_data[(W-1-i)*8 +: 8];
    end
  end

  assign join_empty  = (32'(in_vbytes) <= OFFSET) ? EMPTY_W'(OFFSET - 32'(in_vbytes)) : '0;
  assign flush_data  = {res_q, {(OFFSET*8){1'b0}}};
  assign flush_empty = fe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      fe_q  <= '0;
    end else begin
      res_q <= res_d;
      fe_q  <= fe_d;
    end
  end

endmodule

// File: rtl/stream_header_extractor.sv
// Strips a HEADER_BYTES header from each Avalon-ST packet, presents it in parallel,
// and re-emits the byte-aligned payload; supports bypass, short-packet drop and counting.
module stream_header_extractor
  import stream_pack::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned HEADER_BYTES = MAC_HEADER_BYTES,
  parameter int unsigned EMPTY_W      = $clog2(DATA_WIDTH/8)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic [EMPTY_W-1:0]        in_empty,
  output logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [EMPTY_W-1:0]        out_empty,
  input  logic                      out_ready,
  input  logic                      bypass,
  output logic [HEADER_BYTES*8-1:0] header_data,
  output logic                      header_valid,
  output logic                      short_error,
  output logic [15:0]               drop_count
);

  localparam int unsigned W       = bytes_per_word(DATA_WIDTH);
  localparam int unsigned HW      = header_words(HEADER_BYTES, DATA_WIDTH);
  localparam int unsigned O       = header_offset(HEADER_BYTES, DATA_WIDTH);
  localparam int unsigned HB_LAST = (O == 0) ? W : O;
  localparam int unsigned CNT_W   = $clog2(HW + 1);
  localparam int unsigned VB_W    = EMPTY_W + 1;

  state_t                    state_q, state_d, cur;
  logic [CNT_W-1:0]          cnt_q, cnt_d, ccnt;
  logic                      first_q, first_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_sop_q, out_sop_d;
  logic                      out_eop_q, out_eop_d;
  logic [EMPTY_W-1:0]        out_empty_q, out_empty_d;
  logic [HEADER_BYTES*8-1:0] hdr_q, hdr_d;
  logic                      hv_q, hv_d;
  logic                      se_q, se_d;
  logic [15:0]               drop_q, drop_d;

  logic                      adv, acc, cap;
  logic [VB_W-1:0]           vb;
  logic [DATA_WIDTH-1:0]     join_data, flush_data;
  logic [EMPTY_W-1:0]        join_empty, flush_empty;

  function automatic logic [DATA_WIDTH-1:0] keep_bytes(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [VB_W-1:0] n);
    keep_bytes = '0;
    for (int unsigned b = 0; b < W; b++) begin
      if (b < 32'(n)) keep_bytes[(W-1-b)*8 +: 8] = d[(W-1-b)*8 +: 8];
    end
  endfunction

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && (state_q != FLUSH);
  assign acc      = in_valid && in_ready;
  assign vb       = in_eop ? (VB_W'(W) - {1'b0, in_empty}) : VB_W'(W);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_empty_d = out_empty_q;
    hdr_d       = hdr_q;
    hv_d        = 1'b0;
    se_d        = 1'b0;
    drop_d      = drop_q;
    cap         = 1'b0;
    cur         = state_q;
    ccnt        = cnt_q;

    // The sop word is handled by the HDR/BYP rules in the cycle it arrives.
    if (state_q == IDLE && acc && in_sop) begin
      cur  = bypass ? BYP : HDR;
      ccnt = '0;
    end
    if (adv) out_valid_d = 1'b0;

    case (cur)
      FLUSH: if (adv) begin
        out_valid_d = 1'b1;
        out_data_d  = flush_data;
        out_sop_d   = first_q;
        out_eop_d   = 1'b1;
        out_empty_d = flush_empty;
        first_d     = 1'b0;
        state_d     = IDLE;
      end
      BYP: if (acc) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_sop_d   = in_sop;
        out_eop_d   = in_eop;
        out_empty_d = in_empty;
        if (32'(ccnt) < HW) begin
          cap   = 1'b1;
          cnt_d = ccnt + 1'b1;
          if (ccnt == CNT_W'(HW - 1) && (!in_eop || 32'(vb) >= HB_LAST)) hv_d = 1'b1;
        end
        state_d = in_eop ? IDLE : BYP;
      end
      HDR: if (acc) begin
        cap     = 1'b1;
        cnt_d   = ccnt + 1'b1;
        state_d = HDR;
        if (ccnt == CNT_W'(HW - 1)) begin
          if (in_eop && 32'(vb) < HB_LAST) begin
            se_d    = 1'b1;
            drop_d  = drop_q + 16'd1;
            state_d = IDLE;
          end else begin
            hv_d    = 1'b1;
            first_d = 1'b1;
            if (!in_eop) begin
              state_d = PAY;
            end else if (32'(vb) == HB_LAST) begin
              drop_d  = drop_q + 16'd1;
              state_d = IDLE;
            end else begin
              state_d = FLUSH;
            end
          end
        end else if (in_eop) begin
          se_d    = 1'b1;
          drop_d  = drop_q + 16'd1;
          state_d = IDLE;
        end
      end
      PAY: if (acc) begin
        out_valid_d = 1'b1;
        out_sop_d   = first_q;
        first_d     = 1'b0;
        if (O == 0) begin
          out_data_d  = keep_bytes(in_data, vb);
          out_eop_d   = in_eop;
          out_empty_d = in_empty;
          if (in_eop) state_d = IDLE;
        end else begin
          out_data_d  = join_data;
          out_eop_d   = 1'b0;
          out_empty_d = '0;
          if (in_eop) begin
            if (32'(vb) <= O) begin
              out_eop_d   = 1'b1;
              out_empty_d = join_empty;
              state_d     = IDLE;
            end else begin
              state_d = FLUSH;
            end
          end
        end
      end
      default: ;
    endcase

    if (cap) begin
      for (int unsigned j = 0; j < HEADER_BYTES; j++) begin
        if (j / W == 32'(ccnt)) hdr_d[(HEADER_BYTES-1-j)*8 +: 8] = in_data[(W-1-(j%W))*8 +: 8];
      end
    end
  end

  if (O != 0) begin : g_realign
    logic load;
    assign load = acc && ((cur == PAY) || (cur == HDR && ccnt == CNT_W'(HW - 1)));
    st_byte_realigner #(
      .DATA_WIDTH(DATA_WIDTH),
      .OFFSET    (O),
      .EMPTY_W   (EMPTY_W)
    ) u_realign (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_vbytes  (vb),
      .load       (load),
      .join_data  (join_data),
      .join_empty (join_empty),
      .flush_data (flush_data),
      .flush_empty(flush_empty)
    );
  end else begin : g_no_realign
    assign join_data   = '0;
    assign join_empty  = '0;
    assign flush_data  = '0;
    assign flush_empty = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
      hdr_q       <= '0;
      hv_q        <= 1'b0;
      se_q        <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_empty_q <= out_empty_d;
      hdr_q       <= hdr_d;
      hv_q        <= hv_d;
      se_q        <= se_d;
      drop_q      <= drop_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_sop      = out_sop_q;
  assign out_eop      = out_eop_q;
  assign out_empty    = out_empty_q;
  assign header_data  = hdr_q;
  assign header_valid = hv_q;
  assign short_error  = se_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_stream_header_extractor.sv
// Directed bench: one extractor with a 12-byte header (word aligned) and one with 14 bytes.
module tb_stream_header_extractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, bypass = 1'b0, out_ready = 1'b1;
  logic [1:0]  in_empty = '0;

  logic        r12, ov12, sop12, eop12, hv12, se12;
  logic [31:0] od12;
  logic [1:0]  emp12;
  logic [95:0] hdr12;
  logic [15:0] drop12;
  logic        r14, ov14, sop14, eop14, hv14, se14;
  logic [31:0] od14;
  logic [1:0]  emp14;
  logic [111:0] hdr14;
  logic [15:0] drop14;

  always #5 clk = ~clk;

  stream_header_extractor #(.DATA_WIDTH(32), .HEADER_BYTES(12)) u12 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_ready(r12), .out_data(od12), .out_valid(ov12),
    .out_sop(sop12), .out_eop(eop12), .out_empty(emp12), .out_ready(out_ready), .bypass(bypass),
    .header_data(hdr12), .header_valid(hv12), .short_error(se12), .drop_count(drop12));

  stream_header_extractor #(.DATA_WIDTH(32), .HEADER_BYTES(14)) u14 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_ready(r14), .out_data(od14), .out_valid(ov14),
    .out_sop(sop14), .out_eop(eop14), .out_empty(emp14), .out_ready(out_ready), .bypass(bypass),
    .header_data(hdr14), .header_valid(hv14), .short_error(se14), .drop_count(drop14));

  int sel = 0;
  logic         c_ready, c_ov, c_sop, c_eop, c_hv, c_se;
  logic [31:0]  c_od;
  logic [1:0]   c_emp;
  logic [111:0] c_hdr;
  logic [15:0]  c_drop;
  assign c_ready = (sel != 0) ? r14   : r12;
  assign c_ov    = (sel != 0) ? ov14  : ov12;
  assign c_sop   = (sel != 0) ? sop14 : sop12;
  assign c_eop   = (sel != 0) ? eop14 : eop12;
  assign c_hv    = (sel != 0) ? hv14  : hv12;
  assign c_se    = (sel != 0) ? se14  : se12;
  assign c_od    = (sel != 0) ? od14  : od12;
  assign c_emp   = (sel != 0) ? emp14 : emp12;
  assign c_hdr   = (sel != 0) ? hdr14 : {16'h0, hdr12};
  assign c_drop  = (sel != 0) ? drop14 : drop12;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  e;
  } word_t;

  typedef struct {
    bit           rst;
    int           sel, start, len, n;
    logic [31:0]  d [3];
    logic [1:0]   e;
    int           hv, se, drop, rlow;
    logic [111:0] hdr;
  } vec_t;

  word_t rx[$];
  word_t sent[$];
  int n_cmp = 0, n_bad = 0;
  int hv_cnt, se_cnt, rlow;
  bit in_acc, stalled;
  logic [36:0]  hold;
  logic [111:0] hdr_seen;
  vec_t vec [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkvec(bit r, int s, int st, int ln, int n, logic [31:0] d0,
                                 logic [31:0] d1, logic [31:0] d2, logic [1:0] e, int hv,
                                 int se, int dr, int rl, logic [111:0] h);
    vec_t v;
    v.rst = r; v.sel = s; v.start = st; v.len = ln; v.n = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.e = e;
    v.hv = hv; v.se = se; v.drop = dr; v.rlow = rl; v.hdr = h;
    return v;
  endfunction

  function automatic logic [31:0] mkword(int start, int len, int k);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) begin
      int idx = k * 4 + b;
      w[(3-b)*8 +: 8] = (idx < len) ? 8'(start + idx) : 8'hAA;
    end
    return w;
  endfunction

  // One cycle: sample in the low phase, then move to the next falling edge.
  task automatic tick();
    #1;
    in_acc = in_valid && c_ready;
    if (!c_ready) rlow++;
    if (c_hv) begin hv_cnt++; hdr_seen = c_hdr; end
    if (c_se) se_cnt++;
    if (stalled) check("stall_hold", {91'h0, c_ov, c_od, c_sop, c_eop, c_emp}, {91'h0, hold});
    if (c_ov && out_ready) rx.push_back({c_od, c_sop, c_eop, c_emp});
    stalled = c_ov && !out_ready;
    hold = {c_ov, c_od, c_sop, c_eop, c_emp};
    @(negedge clk);
  endtask

  task automatic drive_word(input int start, input int len, input int k, input bit byp);
    int nw = (len + 3) / 4;
    in_valid = 1'b1;
    in_data  = mkword(start, len, k);
    in_sop   = (k == 0);
    in_eop   = (k == nw - 1);
    in_empty = (k == nw - 1) ? 2'(nw * 4 - len) : 2'd0;
    bypass   = byp;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0; in_data = '0; bypass = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stalled = 1'b0;
  endtask

  task automatic send_packet(input int start, input int len, input bit byp, input int mode);
    int nw = (len + 3) / 4;
    int k = 0;
    int cyc = 0;
    sent.delete();
    while (k < nw && cyc < 200) begin
      drive_word(start, len, k, byp);
      if (mode == 0)    out_ready = 1'b1;
      else if (cyc < 8) out_ready = (cyc % 2 == 0);
      else              out_ready = 1'($urandom_range(0, 1));
      tick();
      if (in_acc) begin
        sent.push_back({in_data, in_sop, in_eop, in_empty});
        k++;
      end
      cyc++;
    end
    if (k < nw) check("send_timeout", k, nw);
    idle_inputs();
    out_ready = 1'b1;
    repeat (10) tick();
  endtask

  task automatic clear_obs();
    rx.delete(); hv_cnt = 0; se_cnt = 0; rlow = 0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    if (v.rst) do_reset();
    sel = v.sel;
    clear_obs();
    send_packet(v.start, v.len, 1'b0, 0);
    check($sformatf("v%0d_nout", id), rx.size(), v.n);
    for (int i = 0; i < v.n && i < rx.size(); i++) begin
      check($sformatf("v%0d_data%0d", id, i), rx[i].d, v.d[i]);
      check($sformatf("v%0d_sop%0d", id, i), rx[i].sop, (i == 0));
      check($sformatf("v%0d_eop%0d", id, i), rx[i].eop, (i == v.n - 1));
      check($sformatf("v%0d_empty%0d", id, i), rx[i].e, (i == v.n - 1) ? v.e : 2'd0);
    end
    check($sformatf("v%0d_hvalid", id), hv_cnt, v.hv);
    check($sformatf("v%0d_short", id), se_cnt, v.se);
    check($sformatf("v%0d_drops", id), c_drop, v.drop);
    check($sformatf("v%0d_ready_low", id), rlow, v.rlow);
    if (v.hv != 0) check($sformatf("v%0d_header", id), hdr_seen, v.hdr);
  endtask

  initial begin
    vec_t v;
    //              rst sel start len n  d0            d1            d2            e  hv se dr rl header
    vec[0] = mkvec(1, 0, 'h00, 20, 2, 32'h0C0D0E0F, 32'h10111213, 32'h0, 2'd0, 1, 0, 0, 0, 112'h000102030405060708090A0B);
    vec[1] = mkvec(1, 1, 'h00, 19, 2, 32'h0E0F1011, 32'h12000000, 32'h0, 2'd3, 1, 0, 0, 1, 112'h000102030405060708090A0B0C0D);
    vec[2] = mkvec(1, 1, 'h00, 10, 0, 32'h0,        32'h0,        32'h0, 2'd0, 0, 1, 1, 0, 112'h0);
    vec[3] = mkvec(0, 1, 'h20, 20, 2, 32'h2E2F3031, 32'h32330000, 32'h0, 2'd2, 1, 0, 1, 1, 112'h202122232425262728292A2B2C2D);
    vec[4] = mkvec(1, 1, 'h40, 14, 0, 32'h0,        32'h0,        32'h0, 2'd0, 1, 0, 1, 0, 112'h404142434445464748494A4B4C4D);
    vec[5] = mkvec(1, 0, 'h00, 12, 0, 32'h0,        32'h0,        32'h0, 2'd0, 1, 0, 1, 0, 112'h000102030405060708090A0B);
    vec[6] = mkvec(0, 0, 'h50, 10, 0, 32'h0,        32'h0,        32'h0, 2'd0, 0, 1, 2, 0, 112'h0);
    vec[7] = mkvec(1, 1, 'h00, 15, 1, 32'h0E000000, 32'h0,        32'h0, 2'd3, 1, 0, 0, 1, 112'h000102030405060708090A0B0C0D);
    vec[8] = mkvec(1, 1, 'h00, 17, 1, 32'h0E0F1000, 32'h0,        32'h0, 2'd1, 1, 0, 0, 0, 112'h000102030405060708090A0B0C0D);
    vec[9] = mkvec(1, 0, 'h00, 22, 3, 32'h0C0D0E0F, 32'h10111213, 32'h14150000, 2'd2, 1, 0, 0, 0, 112'h000102030405060708090A0B);

    do_reset();
    #1;
    check("rst_out12", {ov12, sop12, eop12, emp12, od12}, '0);
    check("rst_hdr12", hdr12, '0);
    check("rst_pulses12", {hv12, se12}, '0);
    check("rst_drop12", drop12, '0);
    check("rst_ready12", r12, 1'b1);
    check("rst_out14", {ov14, sop14, eop14, emp14, od14, hdr14, drop14}, '0);
    check("rst_ready14", r14, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vec[i], i);

    // Bypass with back-pressure: output must equal the accepted input word for word.
    do_reset();
    sel = 0;
    clear_obs();
    send_packet('h60, 20, 1'b1, 1);
    check("byp_nout", rx.size(), sent.size());
    check("byp_nsent", sent.size(), 5);
    for (int i = 0; i < rx.size() && i < sent.size(); i++)
      check($sformatf("byp_word%0d", i), rx[i], sent[i]);
    check("byp_hvalid", hv_cnt, 1);
    check("byp_header", hdr_seen, 112'h606162636465666768696A6B);
    check("byp_drops", c_drop, 0);

    // Reset while the third payload word is being presented.
    do_reset();
    sel = 0;
    clear_obs();
    begin
      int k = 0;
      int cyc = 0;
      while (k < 5 && cyc < 50) begin
        drive_word('h80, 32, k, 1'b0);
        tick();
        if (in_acc) k++;
        cyc++;
      end
      if (k < 5) check("mid_timeout", k, 5);
    end
    drive_word('h80, 32, 5, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_rst_out", {ov12, sop12, eop12, emp12, od12}, '0);
    check("mid_rst_hdr", hdr12, '0);
    check("mid_rst_pulses", {hv12, se12, drop12}, '0);
    check("mid_rst_ready", r12, 1'b1);
    rst = 1'b0;
    stalled = 1'b0;
    clear_obs();
    drive_word('h80, 32, 6, 1'b0);
    tick();
    drive_word('h80, 32, 7, 1'b0);
    tick();
    idle_inputs();
    repeat (6) tick();
    check("mid_discard_nout", rx.size(), 0);
    check("mid_discard_hvalid", hv_cnt, 0);
    v = vec[0];
    v.rst = 1'b0;
    run_vec(v, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/stream_header_extractor.md
Name: stream_header_extractor

Overview:
- Parametrised successor to the fixed-width MAC header stripper on the Avalon-ST receive path.
- Captures a header of HEADER_BYTES bytes from each packet and presents it on a parallel port with a one-cycle valid pulse.
- Removes the header and re-aligns the payload to byte 0 when HEADER_BYTES is not a multiple of the word size, then emits the payload as a new Avalon-ST packet.
- Additionally supports per-packet bypass, short-packet detection and a drop counter.

Parameters:
- DATA_WIDTH, 32: stream width in bits; multiple of 8, at least 16. W = DATA_WIDTH/8 bytes per word.
- HEADER_BYTES, 12: header length in bytes, at least 1. HW = ceil(HEADER_BYTES/W) header words; O = HEADER_BYTES mod W.
- EMPTY_W, $clog2(DATA_WIDTH/8): width of the empty fields.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_data  in  DATA_WIDTH  input word; first byte is in the MSBs
- in_valid  in  1  input word valid
- in_sop  in  1  start of packet
- in_eop  in  1  end of packet
- in_empty  in  EMPTY_W  unused low bytes on the eop word
- in_ready  out  1  input ready
- out_data  out  DATA_WIDTH  payload word
- out_valid  out  1  payload word valid
- out_sop  out  1  payload start of packet
- out_eop  out  1  payload end of packet
- out_empty  out  EMPTY_W  unused low bytes on the eop word
- out_ready  in  1  downstream ready
- bypass  in  1  sampled on the accepted sop word; 1 passes the packet unmodified
- header_data  out  HEADER_BYTES*8  captured header; first byte in the MSBs
- header_valid  out  1  one-cycle pulse when the header is complete
- short_error  out  1  one-cycle pulse when a packet ends inside the header
- drop_count  out  16  wrapping count of dropped packets

Behaviour:
- Reset values: state=IDLE; out_valid=0, out_sop=0, out_eop=0, out_data=0, out_empty=0; header_data=0; header_valid=0; short_error=0; drop_count=0; residue cleared. in_ready after reset = 1.
- Transfer rule: a word transfers when valid && ready on the same edge. Output is a single register stage with 1-cycle latency.
  - in_ready = (!out_valid || out_ready) && state != FLUSH.
  - out_* hold stable while out_valid && !out_ready.
- V = W - in_empty on eop words; V = W otherwise.
- IDLE:
  - Words without sop are discarded silently.
  - On sop: latch bypass, clear the header word counter, go to HDR (or BYP if bypass=1).
  - The sop word is processed by the HDR/BYP rules in the same cycle.
- BYP:
  - Each input word is copied to the output, including sop/eop/empty.
  - Header bytes are still captured; header_valid pulses as in HDR.
  - eop returns to IDLE.
- HDR: header bytes are shifted into header_data; the counter increments per word.
  - Header-completing word (word HW-1) has O header bytes (W bytes if O=0).
    - header_valid pulses the next cycle.
    - Bytes after the header are stored as residue (W-O bytes; none if O=0); go to PAY with first_out=1.
  - eop before the header is complete: short_error pulses, drop_count++, header_valid stays 0, go to IDLE.
  - eop on the header-completing word:
    - payload = 0 bytes: drop_count++ and go to IDLE; header_valid still pulses.
    - V > O: go to FLUSH to emit one word of V-O bytes with sop+eop.
- PAY, O=0: the input word passes straight through. out_sop = first_out. eop/empty are copied.
- PAY, O≠0: out_data = {residue, first O bytes of in_data}; the new residue is the last W-O bytes.
  - Non-eop words: out_sop = first_out; first_out clears after the first emitted word.
  - eop with V ≤ O: out_eop=1, out_empty = O-V; go to IDLE.
  - eop with V > O: emit a full word with eop=0; go to FLUSH with V-O residue bytes.
- FLUSH:
  - Emits the residue, left-aligned, with eop=1, out_empty = W-(V-O), and sop = first_out.
  - in_ready is 0.
  - Returns to IDLE on acceptance (when !out_valid || out_ready).
- Edge cases:
  - A sop seen outside IDLE is ignored and treated as data.
  - drop_count wraps from 0xFFFF to 0.
  - Reset mid-packet discards the partial packet and the pending output word; the next accepted word must carry sop.
- Unused out_data bytes on eop words are 0.

Decomposition:
- Package stream_pack holds:
  - the state enum (IDLE, HDR, BYP, PAY, FLUSH);
  - the functions bytes_per_word(), header_words() and header_offset();
  - the default MAC_HEADER_BYTES = 12.
- One sub-module, st_byte_realigner: holds the residue and performs the O-byte shift and empty computation. Instantiate it only when O≠0.

Test Plan:
- W=4, H=12, 20-byte packet with bytes 00..13:
  - header_data = 000102..0B, one header_valid pulse;
  - out = 0C0D0E0F (sop), then 10111213 (eop, empty 0).
- W=4, H=14, 19-byte packet with bytes 00..12 (last word empty=1):
  - header = 00..0D;
  - out = 0E0F1011 (sop), then 12000000 (eop, empty 3) via FLUSH, with in_ready low for 1 cycle.
- H=14, 10-byte packet:
  - no output, short_error pulse, header_valid stays 0, drop_count = 1;
  - a following 20-byte packet is extracted correctly.
- H=14, 14-byte packet:
  - header_valid pulses, no output packet, drop_count increments.
- bypass=1 with a 20-byte packet, and out_ready toggled 1010… then random 50%:
  - output is byte-identical to the input, header_valid pulses;
  - no word is lost or duplicated, and out_* stay stable while stalled.
- rst asserted on the 3rd payload word of a packet:
  - all outputs return to reset values the next cycle;
  - a subsequent clean packet is processed correctly.
